// File: rtl/mn_matrix_pkg.sv
// Shared matrix package: default sizes, reader state encoding and the
// mn_matrix access bundle (matrix_io) used by the matrix unloaders.
package mn_matrix_pkg;

  localparam int unsigned MN_DATA_W  = 32;
  localparam int unsigned MN_MAX_DIM = 8;
  localparam int unsigned MN_IDX_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } mn_state_t;

  typedef struct packed {
    logic       read;
    logic [7:0] m_addr;
    logic [7:0] n_addr;
    logic       transpose;
  } matrix_io_t;

  typedef struct packed {
    logic                vld;
    logic [MN_IDX_W-1:0] idx;
  } rd_tag_t;

  function automatic logic dims_ok(input logic [7:0] m, input logic [7:0] n,
                                   input int unsigned max_dim);
    return (m != 8'd0) && (n != 8'd0) &&
           (32'(m) <= max_dim) && (32'(n) <= max_dim);
  endfunction

endpackage

// File: rtl/mn_addr_gen.sv
// Row-major (m,n) address walker shared by the matrix unloaders.
module mn_addr_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       step,
  input  logic [7:0] n_dim,
  input  logic [7:0] m_dim,
  output logic [7:0] m_addr,
  output logic [7:0] n_addr,
  output logic       last
);

  logic row_end;

  assign row_end = (n_addr == n_dim - 8'd1);
  assign last    = row_end && (m_addr == m_dim - 8'd1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      m_addr <= '0;
      n_addr <= '0;
    end else if (step) begin
      if (row_end) begin
        n_addr <= '0;
        m_addr <= m_addr + 8'd1;
      end else begin
        n_addr <= n_addr + 8'd1;
      end
    end
  end

endmodule

// File: rtl/mn_matrix_reader.sv
// Unloads an m x n matrix from mn_matrix one element per cycle into a
// packed row-major vector, pulsing done (with error on bad dimensions).
module mn_matrix_reader
  import mn_matrix_pkg::*;
#(
  parameter int unsigned DATA_W   = MN_DATA_W,
  parameter int unsigned MAX_DIM  = MN_MAX_DIM,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [7:0]                        m_dim,
  input  logic [7:0]                        n_dim,
  output logic                              read,
  output logic [7:0]                        m_addr,
  output logic [7:0]                        n_addr,
  output logic                              transpose,
  input  logic [DATA_W-1:0]                 data_in,
  output logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matrix_out,
  output logic                              busy,
  output logic                              done,
  output logic                              error
);

  mn_state_t           state, state_nxt;
  logic [7:0]          m_lat, n_lat;
  logic                err_q, bad_pend, accept, req_ok;
  logic [MN_IDX_W-1:0] drain_cnt, cur_idx;
  logic                gen_last;
  logic [7:0]          gen_m, gen_n;
  matrix_io_t          io;
  rd_tag_t             pipe [READ_LAT];
  rd_tag_t             tail;

  assign req_ok = dims_ok(m_dim, n_dim, MAX_DIM);
  assign accept = (state == IDLE) && !bad_pend && start;

  mn_addr_gen u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != ISSUE),
    .step   (state == ISSUE),
    .n_dim  (n_lat),
    .m_dim  (m_lat),
    .m_addr (gen_m),
    .n_addr (gen_n),
    .last   (gen_last)
  );

  // A rejected request spends one busy cycle in IDLE on its latched
  // dimensions before moving to FINISH, so error reports two cycles out.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bad_pend)    state_nxt = FINISH;
        else if (accept) state_nxt = req_ok ? ISSUE : IDLE;
      end
      ISSUE:  if (gen_last) state_nxt = DRAIN;
      DRAIN:  if (drain_cnt == MN_IDX_W'(READ_LAT - 1)) state_nxt = FINISH;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      m_lat     <= '0;
      n_lat     <= '0;
      err_q     <= 1'b0;
      bad_pend  <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + MN_IDX_W'(1) : '0;
      if (accept) begin
        m_lat    <= m_dim;
        n_lat    <= n_dim;
        err_q    <= !req_ok;
        bad_pend <= !req_ok;
      end else if (bad_pend) begin
        bad_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    io = '0;
    if (state == ISSUE) begin
      io.read   = 1'b1;
      io.m_addr = gen_m;
      io.n_addr = gen_n;
    end
  end

  assign read      = io.read;
  assign m_addr    = io.m_addr;
  assign n_addr    = io.n_addr;
  assign transpose = io.transpose;
  assign busy      = (state == ISSUE) || (state == DRAIN) || bad_pend;
  assign done      = (state == FINISH);
  assign error     = (state == FINISH) && err_q;

  assign cur_idx = MN_IDX_W'(gen_m) * MN_IDX_W'(n_lat) + MN_IDX_W'(gen_n);

  // Each read carries its destination slot down the latency pipe so the
  // capture uses the address that produced data_in, not the live one.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < READ_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{vld: io.read, idx: cur_idx};
      for (int unsigned i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail = pipe[READ_LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      matrix_out <= '0;
    end else if (accept) begin
      matrix_out <= '0;
    end else if (tail.vld) begin
      for (int unsigned k = 0; k < MAX_DIM * MAX_DIM; k++) begin
        if (tail.idx == MN_IDX_W'(k)) matrix_out[k*DATA_W +: DATA_W] <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_mn_matrix_reader.sv
// Directed bench for mn_matrix_reader against a one-cycle-latency memory model.
module tb_mn_matrix_reader;

  localparam int OUT_W = 8 * 8 * 32;

  logic             clk = 1'b0;
  logic             reset, start;
  logic [7:0]       m_dim, n_dim;
  logic             read, transpose, busy, done, error;
  logic [7:0]       m_addr, n_addr;
  logic [31:0]      data_in;
  logic [OUT_W-1:0] matrix_out;

  logic [31:0] mem [8][8];
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          m;
    int          n;
    logic [31:0] base;
    int          reads;
    int          done_cyc;
    bit          err;
    int          inj;
  } vec_t;

  vec_t vecs[11];

  mn_matrix_reader #(.DATA_W(32), .MAX_DIM(8), .READ_LAT(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .m_dim      (m_dim),
    .n_dim      (n_dim),
    .read       (read),
    .m_addr     (m_addr),
    .n_addr     (n_addr),
    .transpose  (transpose),
    .data_in    (data_in),
    .matrix_out (matrix_out),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (read) data_in <= mem[m_addr[2:0]][n_addr[2:0]];
    else      data_in <= 32'hFFFF_FFFF;
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_mat(input string name, input logic [OUT_W-1:0] exp);
    checks++;
    if (matrix_out !== exp) begin
      errors++;
      for (int k = 0; k < 64; k++) begin
        if (matrix_out[k*32 +: 32] !== exp[k*32 +: 32]) begin
          $display("FAIL %s: word %0d got %0h expected %0h", name, k,
                   matrix_out[k*32 +: 32], exp[k*32 +: 32]);
          break;
        end
      end
    end
  endtask

  task automatic load_mem(input vec_t v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mem[r][c] = (r < v.m && c < v.n) ? v.base + 32'(r * v.n + c) : 32'hA5A5_0000;
  endtask

  task automatic run_xfer(input vec_t v);
    int cyc, nreads, done_cyc, em, en;
    bit got_done;
    logic [OUT_W-1:0] exp_mat;
    load_mem(v);
    exp_mat = '0;
    for (int k = 0; k < v.reads; k++) exp_mat[k*32 +: 32] = v.base + 32'(k);
    @(posedge clk); #1;
    m_dim = 8'(v.m); n_dim = 8'(v.n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; nreads = 0; done_cyc = 0; em = 0; en = 0; got_done = 1'b0;
    while (!got_done && cyc < 200) begin
      if (cyc == v.inj) begin
        start = 1'b1; m_dim = 8'd4; n_dim = 8'd4;
      end else begin
        start = 1'b0;
      end
      if (cyc == 1) begin
        chk("busy_c1", busy, 1);
        chk("transpose", transpose, 0);
      end
      if (read) begin
        chk("addr", {m_addr, n_addr}, {8'(em), 8'(en)});
        nreads++;
        en++;
        if (en == v.n) begin en = 0; em++; end
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        chk("error", error, v.err);
        chk_mat("matrix_at_done", exp_mat);
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("done_seen", got_done, 1);
    chk("done_cycle", done_cyc, v.done_cyc);
    chk("read_count", nreads, v.reads);
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse_len", done, 0);
    chk("busy_after_done", busy, 0);
    chk_mat("matrix_hold", exp_mat);
    @(posedge clk); #1;
    chk("idle_after", busy, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_read"}, read, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_addr"}, {m_addr, n_addr}, 0);
    chk({tag, "_transpose"}, transpose, 0);
    chk_mat({tag, "_matrix"}, '0);
  endtask

  initial begin
    int nd;
    vecs[0]  = '{2, 3, 32'd1,          6,  8, 1'b0, 0};
    vecs[1]  = '{1, 1, 32'hDEADBEEF,   1,  3, 1'b0, 0};
    vecs[2]  = '{8, 8, 32'd0,          64, 66, 1'b0, 0};
    vecs[3]  = '{3, 2, 32'd100,        6,  8, 1'b0, 0};
    vecs[4]  = '{0, 3, 32'd0,          0,  2, 1'b1, 0};
    vecs[5]  = '{2, 9, 32'd0,          0,  2, 1'b1, 0};
    vecs[6]  = '{2, 3, 32'd1,          6,  8, 1'b0, 3};
    vecs[7]  = '{2, 3, 32'd1,          6,  8, 1'b0, 8};
    vecs[8]  = '{8, 1, 32'd7,          8,  10, 1'b0, 0};
    vecs[9]  = '{9, 9, 32'd0,          0,  2, 1'b1, 0};
    vecs[10] = '{1, 8, 32'd50,         8,  10, 1'b0, 0};

    reset = 1'b1; start = 1'b0; m_dim = '0; n_dim = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run_xfer(vecs[i]);

    // Abort a 2x3 transfer with reset during its fourth read.
    load_mem(vecs[0]);
    @(posedge clk); #1;
    m_dim = 8'd2; n_dim = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_read4", {read, m_addr, n_addr}, {1'b1, 8'd1, 8'd0});
    reset = 1'b1;
    @(posedge clk); #1;
    chk_zero("abort");
    reset = 1'b0;
    nd = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    chk("abort_quiet", nd, 0);
    run_xfer(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
